// File: rtl/noc_flit_pkg.sv
// Shared flit framing definitions for the NoC datapath blocks.
package noc_flit_pkg;

    // The flit type lives in the top TYPE_W bits of every flit.
    localparam int TYPE_W = 2;

    localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b10;
    localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
    localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b01;
    localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

endpackage

// File: rtl/flit_skid_buf.sv
// Two-entry register buffer absorbing the FIFO read latency; entry 0 is the output head.
module flit_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        occ_q, occ_d;
    logic              valid_q, valid_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        // Pop first so a simultaneous write lands behind whatever remains.
        if (pop_i && occ_q != 2'd0) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (wr_i && occ_d != 2'd2) begin
            if (occ_d == 2'd0) begin
                ent0_d = wr_data_i;
            end else begin
                ent1_d = wr_data_i;
            end
            occ_d = occ_d + 2'd1;
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = ent0_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;

    occ_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) occ_q != 2'd3);

endmodule

// File: rtl/fifo_flit_reader.sv
// Drains a one-cycle-latency FIFO onto a valid/ready flit stream and checks packet framing.
module fifo_flit_reader
    import noc_flit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int ID     = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rd_en_o,
    output logic [DATA_W-1:0] flit_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              in_pkt_o,
    output logic              frame_err_o,
    output logic [CNT_W-1:0]  pkt_cnt_o
);

    logic              pop;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [TYPE_W-1:0] ftype;
    state_e            state_q, state_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    assign pop = skid_valid && ready_i;

    // Flits already owed to the skid (held + in flight) must leave room for the new read.
    assign fifo_rd_en_o = rst_ni && !fifo_empty_i &&
                          (({1'b0, occ} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));
    assign inflight_d   = fifo_rd_en_o;

    flit_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_i      (inflight_q),
        .wr_data_i (fifo_data_i),
        .pop_i     (pop),
        .data_o    (skid_data),
        .valid_o   (skid_valid),
        .occ_o     (occ)
    );

    assign ftype = skid_data[DATA_W-1 -: TYPE_W];

    always_comb begin
        state_d     = state_q;
        frame_err_d = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        if (pop) begin
            case (ftype)
                FLIT_HEAD: begin
                    state_d     = PKT;
                    frame_err_d = (state_q == PKT);
                end
                FLIT_BODY: begin
                    frame_err_d = (state_q == IDLE);
                end
                FLIT_TAIL: begin
                    state_d     = IDLE;
                    frame_err_d = (state_q == IDLE);
                    if (state_q == PKT) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    frame_err_d = (state_q == PKT);
                    pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q  <= 1'b0;
            state_q     <= IDLE;
            frame_err_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            inflight_q  <= inflight_d;
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign flit_o      = skid_data;
    assign valid_o     = skid_valid;
    assign in_pkt_o    = (state_q == PKT);
    assign frame_err_o = frame_err_q;
    assign pkt_cnt_o   = pkt_cnt_q;

    no_overrun_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(occ == 2'd2 && inflight_q && !pop))
        else $error("fifo_flit_reader %0d: skid overrun", ID);

endmodule

// File: doc/fifo_flit_reader.md
Name: fifo_flit_reader

Overview:
- Read-side controller that drains a circ_fifo instance, which has a registered, one-cycle read latency.
- Presents the flits on a valid/ready stream toward the router crossbar or output link.
- Never issues a read to an empty FIFO, so the FIFO's underflow flag can never set.
- Absorbs the read latency with a 2-entry skid buffer so throughput stays at 1 flit/cycle under backpressure.
- Checks head/body/tail flit framing and counts completed packets.

Parameters:
- DATA_W, 8: flit width. Bits [DATA_W-1:DATA_W-2] carry the flit type. Minimum 3.
- CNT_W, 16: width of the completed-packet counter.
- ID, 0: instance identifier, debug display only.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- fifo_empty_i  in  1  empty_o of the drained FIFO.
- fifo_data_i  in  DATA_W  data_o of the FIFO; valid the cycle after an accepted read.
- fifo_rd_en_o  out  1  rd_en_i of the FIFO.
- flit_o  out  DATA_W  output flit.
- valid_o  out  1  flit_o valid.
- ready_i  in  1  downstream accepts; a transfer occurs when valid_o && ready_i.
- in_pkt_o  out  1  1 while between an accepted HEAD and its TAIL.
- frame_err_o  out  1  one-cycle pulse on a framing violation.
- pkt_cnt_o  out  CNT_W  completed packets (TAIL or SINGLE transferred); wraps.

Behaviour:
- Flit type encoding:
  - 2'b10 = HEAD
  - 2'b00 = BODY
  - 2'b01 = TAIL
  - 2'b11 = SINGLE (head and tail)
- Reset values (asynchronous): inflight=0, skid occupancy occ=0, both skid entries 0, flit_o=0, valid_o=0, state=IDLE, in_pkt_o=0, frame_err_o=0, pkt_cnt_o=0.
- fifo_rd_en_o is combinational: pop = valid_o && ready_i; rd_en = !fifo_empty_i && (occ + inflight - pop <= 1).
  - Asserted only when the FIFO is not empty (underflow never occurs).
  - Zero while rst_ni is low.
- inflight register <= fifo_rd_en_o every cycle.
- When inflight=1, fifo_data_i is written into the skid at the tail position.
- Skid buffer:
  - 2-entry FIFO of registers, occupancy 0..2; entry 0 drives flit_o.
  - valid_o = (occ != 0), driven from a registered value.
  - On a simultaneous write and pop, occ is unchanged and entries shift.
  - occ never exceeds 2. Make this a formal assertion; also assert !(occ==2 && inflight && !pop).
- Latency: fifo_empty_i falls in cycle N → rd_en in N → flit in skid at the end of N+1 → valid_o in N+2.
- Sustained throughput is 1 flit/cycle with ready_i held high.
- Backpressure:
  - ready_i=0 holds flit_o stable while valid_o=1.
  - At most 2 flits are buffered; reads stop after that.
  - When ready_i returns, flow resumes with no lost or duplicated flits.
- Framing FSM, evaluated only on a transfer (valid_o && ready_i):
  - IDLE: HEAD → PKT. SINGLE → IDLE, pkt_cnt++. BODY or TAIL → IDLE, frame_err pulse.
  - PKT: BODY → PKT. TAIL → IDLE, pkt_cnt++. HEAD → PKT (abandons the old packet), frame_err pulse. SINGLE → IDLE, pkt_cnt++, frame_err pulse.
- Flits that violate framing are still forwarded, never dropped.
- in_pkt_o = (state == PKT).
- frame_err_o is registered: high for exactly one cycle after the offending transfer.
- pkt_cnt_o wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - Everything returns to the reset values immediately.
  - Flits in the skid buffer and any in-flight read are discarded.
  - Reset of the FIFO itself is the parent's responsibility; both share rst_ni.

Decomposition:
- Shared package noc_flit_pkg holds:
  - flit type localparams FLIT_HEAD=2'b10, FLIT_BODY=2'b00, FLIT_TAIL=2'b01, FLIT_SINGLE=2'b11;
  - the type-field position (top 2 bits of the flit);
  - FSM state encodings IDLE=1'b0, PKT=1'b1.
- One natural sub-module: flit_skid_buf, the 2-entry register buffer with wr/pop/occ.
- The FSM, counter and read-issue logic live in the top.

Test Plan:
- Streaming: FIFO holds HEAD 0x81, BODY 0x05, TAIL 0x42 with ready_i=1 → rd_en on 3 consecutive cycles, valid_o from 2 cycles after the first read, flits 0x81, 0x05, 0x42 on consecutive cycles, pkt_cnt_o=1, frame_err_o never 1.
- Backpressure: 5 flits queued, ready_i=0 for 6 cycles → exactly 2 reads issued, flit_o held at the first flit. Releasing ready_i delivers all 5 in order, none duplicated.
- Empty guard: fifo_empty_i=1 throughout with ready_i toggling → fifo_rd_en_o stays 0 and valid_o stays 0. A single flit 0xC3 (SINGLE) arriving with empty_i low for 1 cycle → exactly 1 read, pkt_cnt_o 0→1.
- Framing errors: BODY 0x01 in IDLE → frame_err_o pulses 1 cycle and the flit is still output. Then HEAD, HEAD → second HEAD pulses the error and in_pkt_o stays 1.
- Counter wrap: CNT_W=2, 5 SINGLE flits 0xC0–0xC4 → pkt_cnt_o sequence 1, 2, 3, 0, 1.
- Reset mid-flow: assert rst_ni low while occ=2 and inflight=1 → valid_o, fifo_rd_en_o, in_pkt_o and pkt_cnt_o are 0 asynchronously (before the next clock edge). After release, no stale flit appears on flit_o.
